// File: rtl/dma_rd_arbiter.sv
// Two-requester round-robin arbiter and burst sequencer for the single read-DMA channel.
// Grants one burst at a time, issues the DMA request, steers beats to the owner and counts them.
module dma_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SIZE_W-1:0] m0_size,
  output logic              m0_grant,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SIZE_W-1:0] m1_size,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic              m1_done,
  output logic [ADDR_W-1:0] dma_raddr,
  output logic              dma_rareq,
  output logic [SIZE_W-1:0] dma_rsize,
  input  logic              dma_rbusy,
  input  logic [DATA_W-1:0] dma_rdata,
  input  logic              dma_rvalid,
  output logic              dma_rready
);

  // state | meaning
  // IDLE  | arbitrate; grant (and finish zero-size bursts) combinationally
  // ISSUE | hold raddr/rsize, pulse dma_rareq once dma_rbusy is low
  // XFER  | pass beats between DMA and owner, count handshakes to the last beat
  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              prio, prio_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [SIZE_W-1:0] size_q, size_nxt;
  logic [SIZE_W-1:0] cnt, cnt_nxt;
  logic              gnt0, gnt1;
  logic [SIZE_W-1:0] size_sel;
  logic              hs;

  assign m0_rdata  = dma_rdata;
  assign m1_rdata  = dma_rdata;
  assign dma_raddr = addr_q;
  assign dma_rsize = size_q;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    prio_nxt   = prio;
    addr_nxt   = addr_q;
    size_nxt   = size_q;
    cnt_nxt    = cnt;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    size_sel   = '0;
    hs         = 1'b0;
    m0_grant   = 1'b0;
    m1_grant   = 1'b0;
    m0_done    = 1'b0;
    m1_done    = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    dma_rareq  = 1'b0;
    dma_rready = 1'b0;
    // Synchronous reset also forces every combinational output low for its duration.
    if (!reset) begin
      case (state)
        IDLE: begin
          gnt0     = m0_req & (~m1_req | ~prio);
          gnt1     = m1_req & (~m0_req | prio);
          size_sel = gnt1 ? m1_size : m0_size;
          if (gnt0 | gnt1) begin
            m0_grant  = gnt0;
            m1_grant  = gnt1;
            owner_nxt = gnt1;
            addr_nxt  = gnt1 ? m1_addr : m0_addr;
            size_nxt  = size_sel;
            cnt_nxt   = '0;
            if (size_sel == '0) begin
              m0_done  = gnt0;
              m1_done  = gnt1;
              prio_nxt = ~gnt1;
            end else begin
              state_nxt = ISSUE;
            end
          end
        end
        ISSUE: begin
          dma_rareq = ~dma_rbusy;
          if (!dma_rbusy) state_nxt = XFER;
        end
        XFER: begin
          dma_rready = owner ? m1_rready : m0_rready;
          m0_rvalid  = ~owner & dma_rvalid;
          m1_rvalid  = owner & dma_rvalid;
          hs         = dma_rvalid & dma_rready;
          if (hs) begin
            cnt_nxt = cnt + SIZE_W'(1);
            if (cnt == size_q - SIZE_W'(1)) begin
              m0_done   = ~owner;
              m1_done   = owner;
              prio_nxt  = ~owner;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      prio   <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      prio   <= prio_nxt;
      addr_q <= addr_nxt;
      size_q <= size_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: doc/dma_rd_arbiter.md
# dma_rd_arbiter

Two-requester arbiter and burst sequencer for the accelerator's single 64-bit read-DMA channel (raddr/rareq/rsize/rbusy/rdata/rvalid/rready). It grants the channel to one requester at a time, round-robin (e.g. m0 = feature-map loader, m1 = weight loader). It issues the DMA request, steers returning beats to the owner, and counts beats to detect end of burst. It sits between the loaders and the top-level DMA pins, in front of the input-registered DMA signals.

## Interface
- ADDR_W, 32, DMA byte-address width
- SIZE_W, 16, burst length width, in 64-bit beats
- DATA_W, 64, DMA data width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mN_req  in  1  requester N wants a burst (N = 0, 1); held until mN_grant
- mN_addr  in  ADDR_W  burst start address, sampled in grant cycle
- mN_size  in  SIZE_W  beat count, sampled in grant cycle
- mN_grant  out  1  one-cycle pulse: request accepted
- mN_rdata  out  DATA_W  beat data (dma_rdata steered)
- mN_rvalid  out  1  beat valid, owner only
- mN_rready  in  1  owner can take beat
- mN_done  out  1  one-cycle pulse on last-beat handshake (or zero-size accept)
- dma_raddr  out  ADDR_W  latched burst address
- dma_rareq  out  1  one-cycle request pulse to DMA
- dma_rsize  out  SIZE_W  latched burst size
- dma_rbusy  in  1  DMA cannot accept a request
- dma_rdata  in  DATA_W  DMA read data
- dma_rvalid  in  1  DMA beat valid
- dma_rready  out  1  beat accepted

## Operation
- State machine IDLE -> ISSUE -> XFER -> IDLE; registers: owner (1b), prio (1b, requester favoured next), addr/size latches, beat counter (SIZE_W).
- IDLE: if only one mN_req is high, grant it. If both are high, grant prio. Pulse mN_grant, latch addr/size, set owner, clear counter.
  - size != 0: go to ISSUE.
  - size == 0: also pulse mN_done in the same cycle, set prio = !owner, stay IDLE (no DMA request).
- ISSUE: dma_rareq = !dma_rbusy. When the pulse fires, go to XFER. Otherwise wait, holding raddr/rsize stable.
- XFER: dma_rready = owner's mN_rready. mOwner_rvalid = dma_rvalid. Non-owner rvalid = 0.
  - A beat is a handshake (dma_rvalid & dma_rready); each beat increments the counter.
  - On a handshake with counter == size-1: pulse mOwner_done, set prio = !owner, go to IDLE.
- dma_rready = 0 outside XFER. Beats arriving then are not accepted.
- mN_rdata = dma_rdata for both requesters (unqualified). Only rvalid is gated.
- mN_req deasserting after grant has no effect; the burst runs to completion.
- A new grant in IDLE is possible the cycle after done; no dead cycle beyond the IDLE visit.
- Counter arithmetic is unsigned SIZE_W; maximum burst 2^SIZE_W-1 beats, with no wrap within a burst.

## Timing
- Reset values: every output 0; state IDLE, owner 0, prio 0 (m0 favoured), counter 0, latches 0.
- Reset mid-burst aborts to IDLE with no done pulse. The DMA engine is reset by the same reset.
- Grant: same cycle req is seen in IDLE (registered state, combinational grant decode, all outputs driven from state/latches).
- Request: dma_rareq rises at the earliest one cycle after grant (first ISSUE cycle) if dma_rbusy = 0.
- dma_rareq is high for exactly one cycle per burst. raddr/rsize are valid from the ISSUE entry until the next grant.
- The ready/valid path is combinational pass-through (zero latency); done is in the same cycle as the last beat handshake.
- dma_rbusy is ignored outside ISSUE.

## Test plan
- Single burst: m0_req, addr=0x1000, size=4, DMA beats back-to-back, ready=1.
  - Expect m0_grant at cycle t, dma_rareq at t+1 with raddr 0x1000 and rsize 4.
  - Expect 4 m0_rvalid beats, m0_done on the 4th, m1_rvalid never high.
- Contention: m0_req and m1_req both high from reset, size=2 each.
  - Expect m0 granted first, m1 granted in the IDLE cycle after m0_done, then m0 again if it re-requests.
- Busy stall: dma_rbusy=1 for 5 cycles during ISSUE.
  - Expect no dma_rareq for those 5 cycles, then exactly one rareq pulse, address stable throughout.
- Backpressure: owner m1_rready toggles 1,0,0,1 with dma_rvalid held high, size=3.
  - Expect dma_rready to mirror m1_rready, the counter to advance only on handshakes, and m1_done on the 3rd accepted beat.
- Zero size and reset: m0 size=0.
  - Expect grant+done in the same cycle with no dma_rareq.
  - Then assert reset mid-XFER of a size-8 burst after 3 beats: expect outputs 0, no done, and m0 favoured on the next contention.
